// File: rtl/arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package arb_pkg;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;
    localparam int unsigned SIZE_WIDTH           = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DRAIN  = 2'd3
    } arbState_t;

endpackage

// File: rtl/starve_counter.sv
// Counts consecutive data grants made while a fetch is waiting; saturates at LIMIT.
module starve_counter
    import arb_pkg::*;
#(
    parameter int unsigned LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             waiting,
    input  logic             grantI,
    input  logic             grantD,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!waiting || grantI) begin
            count <= '0;
        end else if (grantD && (count != CNT_W'(LIMIT))) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data requesters onto one memory port; data has priority
// unless the fetch side has been starved for STARVE_LIMIT consecutive data grants.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifReq,
    input  logic [ADDR_WIDTH-1:0] ifAddr,
    input  logic                  flush,
    output logic                  ifValid,
    output logic [DATA_WIDTH-1:0] ifRdata,
    output logic                  ifStall,
    input  logic                  dReq,
    input  logic                  dWe,
    input  logic [ADDR_WIDTH-1:0] dAddr,
    input  logic [DATA_WIDTH-1:0] dWdata,
    input  logic [SIZE_WIDTH-1:0] dSize,
    output logic                  dValid,
    output logic [DATA_WIDTH-1:0] dRdata,
    output logic                  dStall,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWdata,
    output logic [SIZE_WIDTH-1:0] memSize,
    input  logic                  memReady,
    input  logic [DATA_WIDTH-1:0] memRdata
);

    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    arbState_t        state;
    arbState_t        stateNext;
    logic             arbEn;
    logic             ifEligible;
    logic             grantI;
    logic             grantD;
    logic             starveFull;
    logic [CNT_W-1:0] starveCnt;

    starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .waiting (ifReq),
        .grantI  (grantI),
        .grantD  (grantD),
        .count   (starveCnt)
    );

    assign starveFull = (starveCnt == CNT_W'(STARVE_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Arbitration opens in IDLE and on every completing cycle, so a still-held
    // request re-enters the race with no idle bubble.
    always_comb begin
        stateNext  = state;
        arbEn      = 1'b0;
        ifValid    = 1'b0;
        ifRdata    = '0;
        dValid     = 1'b0;
        dRdata     = '0;
        ifEligible = 1'b0;
        grantI     = 1'b0;
        grantD     = 1'b0;

        case (state)
            IDLE: begin
                arbEn = 1'b1;
            end
            BUSY_I: begin
                if (memReady) begin
                    arbEn = 1'b1;
                    if (!flush) begin
                        ifValid = 1'b1;
                        ifRdata = memRdata;
                    end
                end else if (flush) begin
                    stateNext = DRAIN;
                end
            end
            BUSY_D: begin
                if (memReady) begin
                    arbEn  = 1'b1;
                    dValid = 1'b1;
                    dRdata = memRdata;
                end
            end
            DRAIN: begin
                if (memReady) begin
                    arbEn = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        ifEligible = ifReq & ~flush;
        grantI     = arbEn & ifEligible & (~dReq | starveFull);
        grantD     = arbEn & dReq & ~grantI;

        if (arbEn) begin
            if (grantI) begin
                stateNext = BUSY_I;
            end else if (grantD) begin
                stateNext = BUSY_D;
            end else begin
                stateNext = IDLE;
            end
        end
    end

    // Memory port fields are captured at the grant edge and held until the next arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            memSize  <= '0;
        end else if (grantI) begin
            memReq   <= 1'b1;
            memWe    <= 1'b0;
            memAddr  <= ifAddr;
            memWdata <= '0;
            memSize  <= '0;
        end else if (grantD) begin
            memReq   <= 1'b1;
            memWe    <= dWe;
            memAddr  <= dAddr;
            memWdata <= dWdata;
            memSize  <= dSize;
        end else if (arbEn) begin
            memReq   <= 1'b0;
        end
    end

    assign ifStall = ifReq & ~ifValid;
    assign dStall  = dReq & ~dValid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int          LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifReq;
    logic [AW-1:0] ifAddr;
    logic          flush;
    logic          ifValid;
    logic [DW-1:0] ifRdata;
    logic          ifStall;
    logic          dReq;
    logic          dWe;
    logic [AW-1:0] dAddr;
    logic [DW-1:0] dWdata;
    logic [2:0]    dSize;
    logic          dValid;
    logic [DW-1:0] dRdata;
    logic          dStall;
    logic          memReq;
    logic          memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
    logic [2:0]    memSize;
    logic          memReady;
    logic [DW-1:0] memRdata;

    mem_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ifReq    (ifReq),
        .ifAddr   (ifAddr),
        .flush    (flush),
        .ifValid  (ifValid),
        .ifRdata  (ifRdata),
        .ifStall  (ifStall),
        .dReq     (dReq),
        .dWe      (dWe),
        .dAddr    (dAddr),
        .dWdata   (dWdata),
        .dSize    (dSize),
        .dValid   (dValid),
        .dRdata   (dRdata),
        .dStall   (dStall),
        .memReq   (memReq),
        .memWe    (memWe),
        .memAddr  (memAddr),
        .memWdata (memWdata),
        .memSize  (memSize),
        .memReady (memReady),
        .memRdata (memRdata)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: what the memory port is doing right now (0 none, 1 fetch, 2 data, 3 cancelled fetch)
    int          mKind;
    int          mStarve;
    logic        mWe;
    logic [31:0] mAddr;
    logic [31:0] mWdata;
    logic [2:0]  mSize;
    bit          checkEn = 1'b0;

    task automatic modelReset();
        mKind   = 0;
        mStarve = 0;
    endtask

    task automatic modelUpdate();
        bit arb;
        bit fWin;
        bit dWin;
        if (rst) begin
            modelReset();
            return;
        end
        arb = (mKind == 0) || memReady;
        if (mKind == 1 && flush && !memReady) mKind = 3;
        fWin = arb && ifReq && !flush && (!dReq || mStarve == LIM);
        dWin = arb && dReq && !fWin;
        if (!ifReq || fWin) mStarve = 0;
        else if (dWin && mStarve < LIM) mStarve = mStarve + 1;
        if (fWin) begin
            mKind = 1; mWe = 1'b0; mAddr = ifAddr;
        end else if (dWin) begin
            mKind = 2; mWe = dWe; mAddr = dAddr; mWdata = dWdata; mSize = dSize;
        end else if (arb) begin
            mKind = 0;
        end
    endtask

    logic eIf;
    logic eD;

    // Every cycle outside reset, the DUT must match the model.
    always @(negedge clk) begin
        if (checkEn && !rst) begin
            eIf = (mKind == 1) && memReady && !flush;
            eD  = (mKind == 2) && memReady;
            check("ifValid/ifRdata", 64'({ifValid, ifRdata}), 64'({eIf, (eIf ? memRdata : 32'h0)}));
            check("dValid/dRdata", 64'({dValid, dRdata}), 64'({eD, (eD ? memRdata : 32'h0)}));
            check("stalls", 64'({ifStall, dStall}), 64'({ifReq & ~eIf, dReq & ~eD}));
            check("memReq", 64'(memReq), 64'(mKind != 0));
            check("oneValid", 64'(ifValid & dValid), 64'(0));
            if (mKind != 0) check("memWe/memAddr", 64'({memWe, memAddr}), 64'({mWe, mAddr}));
            if (mKind == 2) check("memWdata/memSize", 64'({memWdata, memSize}), 64'({mWdata, mSize}));
        end
    end

    task automatic drive(input logic iR, input logic [31:0] iA, input logic fl,
                         input logic dR, input logic dW, input logic [31:0] dA,
                         input logic [31:0] dWd, input logic [2:0] dS,
                         input logic mR, input logic [31:0] mD);
        ifReq = iR; ifAddr = iA; flush = fl;
        dReq = dR; dWe = dW; dAddr = dA; dWdata = dWd; dSize = dS;
        memReady = mR; memRdata = mD;
    endtask

    task automatic toNeg();
        @(negedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, $urandom);
            toNeg();
            tick();
        end
    endtask

    logic [9:0]  seq;
    int          cnt;
    logic        fA, dA, rWe, mr, fl, fv, dv;
    logic [31:0] fAddr, rAddr, rWd;
    logic [2:0]  rSz;

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        modelReset();
        checkEn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset memReq/memWe", 64'({memReq, memWe}), 64'(0));
        check("reset memAddr", 64'(memAddr), 64'(0));
        rst = 1'b0;

        // Lone fetch, immediate memReady
        drive(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        toNeg();
        check("fetch cycle1 ifStall/memReq", 64'({ifStall, memReq}), 64'(2'b10));
        tick();
        drive(1, 32'h0, 0, 0, 0, 0, 0, 0, 1, 32'h00500093);
        toNeg();
        check("fetch cycle2 ifValid/ifStall", 64'({ifValid, ifStall}), 64'(2'b10));
        check("fetch cycle2 ifRdata", 64'(ifRdata), 64'(32'h00500093));
        tick();
        idle(3);

        // Simultaneous store and fetch: data first, fetch next
        drive(1, 32'h40, 0, 1, 1, 32'h100, 32'hDEADBEEF, 3'd2, 0, 0);
        toNeg();
        tick();
        drive(1, 32'h40, 0, 0, 0, 0, 0, 0, 1, 32'h1234);
        toNeg();
        check("store grant memWe/memAddr", 64'({memWe, memAddr}), 64'({1'b1, 32'h100}));
        check("store grant memWdata", 64'(memWdata), 64'(32'hDEADBEEF));
        tick();
        drive(1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0);
        toNeg();
        check("fetch after store", 64'({memReq, memWe, memAddr}), 64'({2'b10, 32'h40}));
        tick();
        idle(3);

        // Starvation: four data grants, then one fetch, repeating
        seq = '0;
        for (int i = 0; i < 11; i++) begin
            drive(1, 32'h40, 0, 1, 0, 32'h200, 0, 3'd2, 1, $urandom);
            toNeg();
            if (i > 0) seq = {seq[8:0], (memAddr == 32'h200)};
            tick();
        end
        check("starve pattern", 64'(seq), 64'(10'b1111011110));
        idle(3);

        // Flush in BUSY_I drains, then the waiting load wins
        drive(1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0);
        toNeg();
        tick();
        drive(0, 0, 1, 1, 0, 32'h300, 0, 3'd1, 0, 0);
        toNeg();
        tick();
        drive(0, 0, 0, 1, 0, 32'h300, 0, 3'd1, 0, 0);
        toNeg();
        check("drain memReq/memAddr", 64'({memReq, memAddr}), 64'({1'b1, 32'h80}));
        tick();
        drive(0, 0, 0, 1, 0, 32'h300, 0, 3'd1, 1, 32'h55);
        toNeg();
        check("drain complete no valid", 64'({ifValid, dValid}), 64'(0));
        tick();
        drive(0, 0, 0, 1, 0, 32'h300, 0, 3'd1, 0, 0);
        toNeg();
        check("load after drain", 64'({memReq, memWe, memAddr}), 64'({2'b10, 32'h300}));
        tick();
        idle(3);

        // Reset in BUSY_D abandons the store; it is reissued afterward
        drive(0, 0, 0, 1, 1, 32'h400, 32'h12345678, 3'd2, 0, 0);
        toNeg();
        tick();
        #2 rst = 1'b1;
        #1;
        check("async reset memReq", 64'(memReq), 64'(0));
        modelReset();
        toNeg();
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 1, 1, 32'h400, 32'h12345678, 3'd2, 1, 0);
        toNeg();
        check("after reset no dValid", 64'({dValid, memReq}), 64'(0));
        tick();
        toNeg();
        check("reissue after reset", 64'({memReq, dValid, memAddr}), 64'({2'b11, 32'h400}));
        tick();
        idle(3);

        // Back-to-back loads with memReady always high
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 1, 0, 32'h500 + 32'(i * 4), 0, 3'd2, 1, $urandom);
            toNeg();
            if (i > 0 && memReq && dValid) cnt++;
            tick();
        end
        check("back-to-back dValid count", 64'(cnt), 64'(6));
        idle(3);

        // Randomized traffic
        fA = 0; dA = 0; fAddr = 0; rWe = 0; rAddr = 0; rWd = 0; rSz = 0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                modelReset();
                toNeg();
                tick();
                rst = 1'b0;
                continue;
            end
            mr = ($urandom_range(0, 9) < 6);
            fl = ($urandom_range(0, 15) == 0);
            fv = (mKind == 1) && mr && !fl;
            dv = (mKind == 2) && mr;
            if (fl || !fA || fv) begin
                fA = ($urandom_range(0, 3) != 0);
                fAddr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dA || dv) begin
                dA = ($urandom_range(0, 2) != 0);
                rWe = 1'($urandom);
                rAddr = $urandom;
                rWd = $urandom;
                rSz = 3'($urandom);
            end
            drive(fA, fAddr, fl, dA, rWe, rAddr, rWd, rSz, mr, $urandom);
            toNeg();
            tick();
        end

        checkEn = 1'b0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: byte address width for both requesters and the memory port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: read and write data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4: maximum number of consecutive data grants while a fetch is waiting.
REQ-004 SHALL have ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifReq  in  1  fetch request; held high until ifValid.
- ifAddr  in  ADDR_WIDTH  fetch address.
- flush  in  1  cancels the outstanding or pending fetch.
- ifValid  out  1  fetch completes this cycle.
- ifRdata  out  DATA_WIDTH  fetched instruction word.
- ifStall  out  1  fetch stage must hold.
- dReq  in  1  data request; held high until dValid.
- dWe  in  1  write (1) or read (0).
- dAddr  in  ADDR_WIDTH  data address.
- dWdata  in  DATA_WIDTH  store data.
- dSize  in  3  access size code, passed through unchanged.
- dValid  out  1  data access completes this cycle.
- dRdata  out  DATA_WIDTH  load data.
- dStall  out  1  memory stage must hold.
- memReq  out  1  transaction active on the memory port.
- memWe, memAddr, memWdata, memSize  out  1/ADDR_WIDTH/DATA_WIDTH/3  registered copy of the granted request.
- memReady  in  1  memory completes the current transaction this cycle.
- memRdata  in  DATA_WIDTH  read data, valid when memReady is high.

Function
REQ-005 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, DRAIN.
REQ-006 SHALL, in IDLE or on completion (memReady high in any BUSY_* or DRAIN state), arbitrate among the live requests and register the winner's fields onto mem*, entering BUSY_I or BUSY_D on the next edge; with no request it SHALL enter or stay in IDLE.
REQ-007 SHALL give data priority over fetch, except that fetch wins when starveCnt == STARVE_LIMIT.
REQ-008 SHALL count consecutive data grants made while ifReq is high in starveCnt; starveCnt SHALL clear on a fetch grant or whenever ifReq is low, and SHALL saturate at STARVE_LIMIT.
REQ-009 SHALL assert memReq throughout every BUSY_* and DRAIN cycle and keep mem* stable until memReady.
REQ-010 SHALL, in BUSY_I with memReady high and flush low, assert ifValid combinationally and drive ifRdata = memRdata; in BUSY_D it SHALL do the same with dValid/dRdata. Completion latency is 1 arbitration edge plus memory latency; an immediate memReady gives 2 cycles from request to valid.
REQ-011 SHALL, on flush high in BUSY_I without memReady, move to DRAIN; the DRAIN transaction SHALL complete at memory without asserting ifValid.
REQ-012 SHALL, on flush high while in IDLE or at arbitration, exclude ifReq from that arbitration.
REQ-013 SHALL drive ifStall = ifReq & ~ifValid and dStall = dReq & ~dValid combinationally.
REQ-014 SHALL, when the completing requester still holds its request on the memReady cycle, treat that request as new and eligible for back-to-back arbitration with no idle bubble.
REQ-015 SHALL never assert ifValid and dValid in the same cycle; memWe SHALL be 0 for fetch grants.
REQ-016 SHALL hold ifRdata and dRdata at 0 when the corresponding valid is low.

Reset
REQ-017 SHALL on rst return to IDLE, clear starveCnt and drive memReq, memWe, memAddr, memWdata and memSize to 0 asynchronously.
REQ-018 SHALL, on reset mid-transaction, abandon the transaction; no valid SHALL be produced for it after reset release.

Structure
REQ-019 SHALL place the FSM state enum and the STARVE_LIMIT default in a shared package, arb_pkg.
REQ-020 SHALL be a single module; the starvation counter MAY be a sub-module, starve_counter.

Verification
REQ-021 Scenario: ifReq alone, addr 0x0, memReady on the first BUSY cycle with memRdata 0x00500093 -> ifValid at cycle 2 with ifRdata 0x00500093 and ifStall high for 1 cycle.
REQ-022 Scenario: ifReq and dReq (write, addr 0x100, data 0xDEADBEEF) rise together -> data is granted first, memWe=1; the fetch is granted on the next arbitration.
REQ-023 Scenario: dReq held continuously with ifReq high and memReady always 1 -> exactly 4 data grants, then 1 fetch grant, repeating.
REQ-024 Scenario: flush in BUSY_I with memReady delayed 3 cycles -> DRAIN is entered, no ifValid, and the next pending dReq is granted on the memReady edge.
REQ-025 Scenario: rst asserted in BUSY_D -> memReq is 0 immediately and no dValid after release; the request is reissued cleanly.
REQ-026 Scenario: back-to-back dReq with memReady always 1 -> one dValid per cycle after the first, with memReq never dropping.
